// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter between the writeback stage and the
// long-latency unit, with a pending-write scoreboard and a starvation stall.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [4:0]        lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    input  logic              issue_valid,
    input  logic [4:0]        issue_addr,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    output logic              hazard,
    output logic              stall_req,
    output logic              sb_conflict,
    output logic [31:0]       busy_mask,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              stall_q, stall_d;
    logic              conflict_q, conflict_d;
    logic [31:0]       busy_q, busy_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic wb_accept;
    logic lu_accept;
    logic denied;

    // Grants: wb owns the port unless a starvation stall hands it to lu.
    assign lu_ready  = !wb_valid || stall_q;
    assign wb_accept = wb_valid && !stall_q;
    assign lu_accept = lu_valid && lu_ready;
    assign denied    = lu_valid && !lu_ready;

    // Hazard looks only at registered state; a retiring write still counts.
    assign hazard = busy_q[rs1_addr] | busy_q[rs2_addr];

    assign stall_req   = stall_q;
    assign sb_conflict = conflict_q;
    assign busy_mask   = busy_q;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;

    // Select the accepted writer; x0 completes the handshake without a write.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (wb_accept) begin
            rf_we_d    = (wb_addr != 5'd0);
            rf_waddr_d = wb_addr;
            rf_wdata_d = wb_data;
        end else if (lu_accept) begin
            rf_we_d    = (lu_addr != 5'd0);
            rf_waddr_d = lu_addr;
            rf_wdata_d = lu_data;
        end
    end

    // Count consecutive denied lu cycles and request a stall on the last one.
    always_comb begin
        wait_cnt_d = '0;
        if (denied) begin
            if (wait_cnt_q == WAIT_MAX) begin
                wait_cnt_d = WAIT_MAX;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
        stall_d = denied && (wait_cnt_q == WAIT_LAST);
    end

    // Scoreboard: retire clears, issue sets afterwards so set wins.
    always_comb begin
        busy_d = busy_q;
        if (lu_accept) begin
            busy_d[lu_addr] = 1'b0;
        end
        if (issue_valid) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
        conflict_d = issue_valid && (issue_addr != 5'd0) &&
                     busy_q[issue_addr];
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            stall_q    <= 1'b0;
            conflict_q <= 1'b0;
            busy_q     <= '0;
            wait_cnt_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            stall_q    <= stall_d;
            conflict_q <= conflict_d;
            busy_q     <= busy_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter: per-cycle table plus
// hand-written reset/starvation sequence.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        hazard;
    logic        stall_req;
    logic        sb_conflict;
    logic [31:0] busy_mask;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready),
        .lu_addr(lu_addr), .lu_data(lu_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .hazard(hazard), .stall_req(stall_req),
        .sb_conflict(sb_conflict), .busy_mask(busy_mask),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    typedef struct {
        logic        wbv;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        luv;
        logic [4:0]  lua;
        logic [31:0] lud;
        logic        isv;
        logic [4:0]  isa;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_rdy;
        logic        e_hz;
        logic        e_st;
        logic        e_cf;
        logic        e_we;
        logic        cw;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
        input logic luv, input logic [4:0] lua, input logic [31:0] lud,
        input logic isv, input logic [4:0] isa,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic rdy, input logic hz, input logic st, input logic cf,
        input logic we, input logic cw, input logic [4:0] wa,
        input logic [31:0] wd, input logic [31:0] busy);
        vec_t r;
        r.wbv = wbv; r.wba = wba; r.wbd = wbd;
        r.luv = luv; r.lua = lua; r.lud = lud;
        r.isv = isv; r.isa = isa; r.rs1 = rs1; r.rs2 = rs2;
        r.e_rdy = rdy; r.e_hz = hz; r.e_st = st; r.e_cf = cf;
        r.e_we = we; r.cw = cw; r.e_wa = wa; r.e_wd = wd;
        r.e_busy = busy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        wb_valid = x.wbv; wb_addr = x.wba; wb_data = x.wbd;
        lu_valid = x.luv; lu_addr = x.lua; lu_data = x.lud;
        issue_valid = x.isv; issue_addr = x.isa;
        rs1_addr = x.rs1; rs2_addr = x.rs2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        wb_valid = 0; wb_addr = 0; wb_data = 0;
        lu_valid = 0; lu_addr = 0; lu_data = 0;
        issue_valid = 0; issue_addr = 0;
        rs1_addr = 0; rs2_addr = 0;
    endtask

    initial begin
        int n;
        bit seen;

        // Per-cycle vectors; registered expectations reflect the previous row.
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,0,0,
                         1,0,0,0,0,1,0,32'h0,0));
        vecs.push_back(v(1,5,32'hDEADBEEF, 0,0,0, 0,0,0,0,
                         0,0,0,0,0,1,0,32'h0,0));
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,0,0,
                         1,0,0,0,1,1,5,32'hDEADBEEF,0));
        vecs.push_back(v(0,0,0, 1,0,32'h1234, 0,0,0,0,
                         1,0,0,0,0,1,5,32'hDEADBEEF,0));
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,0,0,
                         1,0,0,0,0,0,0,32'h0,0));
        vecs.push_back(v(0,0,0, 1,3,32'h33, 0,0,0,0,
                         1,0,0,0,0,0,0,32'h0,0));
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,0,0,
                         1,0,0,0,1,1,3,32'h33,0));
        vecs.push_back(v(1,9,32'h99, 1,7,32'h77, 0,0,0,0,
                         0,0,0,0,0,1,3,32'h33,0));
        vecs.push_back(v(1,9,32'h99, 1,7,32'h77, 0,0,0,0,
                         0,0,0,0,1,1,9,32'h99,0));
        vecs.push_back(v(1,9,32'h99, 1,7,32'h77, 0,0,0,0,
                         0,0,0,0,1,1,9,32'h99,0));
        vecs.push_back(v(1,9,32'h99, 1,7,32'h77, 0,0,0,0,
                         0,0,0,0,1,1,9,32'h99,0));
        vecs.push_back(v(1,9,32'h99, 1,7,32'h77, 0,0,0,0,
                         1,0,1,0,1,1,9,32'h99,0));
        vecs.push_back(v(1,9,32'h99, 0,0,0, 0,0,0,0,
                         0,0,0,0,1,1,7,32'h77,0));
        vecs.push_back(v(0,0,0, 0,0,0, 1,10,0,0,
                         1,0,0,0,1,1,9,32'h99,0));
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,10,0,
                         1,1,0,0,0,1,9,32'h99,32'h400));
        vecs.push_back(v(0,0,0, 1,10,32'hAA, 0,0,10,0,
                         1,1,0,0,0,1,9,32'h99,32'h400));
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,10,0,
                         1,0,0,0,1,1,10,32'hAA,0));
        vecs.push_back(v(0,0,0, 0,0,0, 1,12,0,0,
                         1,0,0,0,0,1,10,32'hAA,0));
        vecs.push_back(v(0,0,0, 0,0,0, 1,12,0,0,
                         1,0,0,0,0,1,10,32'hAA,32'h1000));
        vecs.push_back(v(0,0,0, 1,12,32'hCC, 1,12,0,0,
                         1,0,0,1,0,1,10,32'hAA,32'h1000));
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,0,12,
                         1,1,0,1,1,1,12,32'hCC,32'h1000));
        vecs.push_back(v(0,0,0, 0,0,0, 1,0,0,12,
                         1,1,0,0,0,1,12,32'hCC,32'h1000));
        vecs.push_back(v(0,0,0, 0,0,0, 0,0,0,0,
                         1,0,0,0,0,1,12,32'hCC,32'h1000));

        reset = 1'b1;
        set_idle();
        next_cycle();
        next_cycle();
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #2;
            chk($sformatf("v%0d lu_ready", i), 32'(lu_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d hazard", i), 32'(hazard), 32'(vecs[i].e_hz));
            chk($sformatf("v%0d stall_req", i), 32'(stall_req), 32'(vecs[i].e_st));
            chk($sformatf("v%0d sb_conflict", i), 32'(sb_conflict), 32'(vecs[i].e_cf));
            chk($sformatf("v%0d rf_we", i), 32'(rf_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d busy_mask", i), busy_mask, vecs[i].e_busy);
            if (vecs[i].cw) begin
                chk($sformatf("v%0d rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].e_wa));
                chk($sformatf("v%0d rf_wdata", i), rf_wdata, vecs[i].e_wd);
            end
            next_cycle();
        end

        // Reset in the middle of a starvation wait with a pending mark.
        reset = 1'b1;
        set_idle();
        next_cycle();
        reset = 1'b0;
        issue_valid = 1; issue_addr = 10;
        next_cycle();
        issue_valid = 0; issue_addr = 0;
        wb_valid = 1; wb_addr = 9; wb_data = 32'h99;
        lu_valid = 1; lu_addr = 7; lu_data = 32'h77;
        #2;
        chk("pre-reset busy_mask", busy_mask, 32'h400);
        chk("pre-reset lu_ready c0", 32'(lu_ready), 32'd0);
        next_cycle();
        #2;
        chk("pre-reset lu_ready c1", 32'(lu_ready), 32'd0);
        next_cycle();
        reset = 1'b1;
        #2;
        chk("at-reset lu_ready", 32'(lu_ready), 32'd0);
        next_cycle();
        reset = 1'b0;
        #2;
        chk("post-reset busy_mask", busy_mask, 32'h0);
        chk("post-reset rf_we", 32'(rf_we), 32'd0);
        chk("post-reset stall_req", 32'(stall_req), 32'd0);

        // Fresh wait: count denied cycles until lu is granted.
        n = 0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) #2;
            if (lu_ready) begin
                seen = 1;
                break;
            end
            n++;
            next_cycle();
        end
        chk("post-reset grant seen", 32'(seen), 32'd1);
        chk("post-reset denied cycles", 32'(n), 32'd4);
        chk("post-reset stall_req at grant", 32'(stall_req), 32'd1);
        chk("post-reset wb held rf_we", 32'(rf_we), 32'd1);
        next_cycle();
        lu_valid = 0; lu_addr = 0; lu_data = 0;
        #2;
        chk("post-stall stall_req", 32'(stall_req), 32'd0);
        chk("post-stall rf_we", 32'(rf_we), 32'd1);
        chk("post-stall rf_waddr", 32'(rf_waddr), 32'd7);
        chk("post-stall rf_wdata", rf_wdata, 32'h77);
        chk("post-stall lu_ready", 32'(lu_ready), 32'd0);
        next_cycle();
        set_idle();
        #2;
        chk("wb after stall rf_waddr", 32'(rf_waddr), 32'd9);
        chk("wb after stall rf_we", 32'(rf_we), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
